// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants, used by decode and writeback as well as the
// register file itself.
package regfile_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: index mux, hardwired-zero gate, write bypass,
// and the scoreboard hazard term for that port.
module regfile_rd_port
  import regfile_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0]   busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_busy
);

  logic is_zero;
  logic hit;

  always_comb begin
    is_zero = ZERO_REG && (rd_idx == ADDR_WIDTH'(REG_ZERO));
    hit     = BYPASS && wr_en && (wr_idx == rd_idx) && !is_zero;
    rd_data = regs[rd_idx];
    if (is_zero) begin
      rd_data = '0;
    end else if (hit) begin
      rd_data = wr_data;
    end
    // A bypassed read already sees the retiring value, so it is not a hazard.
    rd_busy = busy[rd_idx] && !is_zero && !hit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port, write bypass,
// optional hardwired zero register and an issue/writeback scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         RegWr,
  input  logic [ADDR_WIDTH-1:0]        Rw,
  input  logic [DATA_WIDTH-1:0]        busW,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] Ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] busR,
  input  logic                         claim_en,
  input  logic [ADDR_WIDTH-1:0]        claim_reg,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic                         stall,
  output logic [ADDR_WIDTH:0]          pend_cnt
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t               regs_q [NUM_REGS];
  word_t               regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       pend_q, pend_d;
  logic                wr_ok, claim_ok, set_new, clr_old, wr_live;

  // NOTE: every variable gets a default before any conditional update, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ok    = RegWr && !(ZERO_REG && (Rw == ADDR_WIDTH'(REG_ZERO)));
    claim_ok = claim_en && !(ZERO_REG && (claim_reg == ADDR_WIDTH'(REG_ZERO)));
    regs_d   = regs_q;
    busy_d   = busy_q;
    if (wr_ok) begin
      regs_d[Rw] = busW;
      busy_d[Rw] = 1'b0;
    end
    // Claim is applied after the writeback clear so a same-register claim wins.
    if (claim_ok) begin
      busy_d[claim_reg] = 1'b1;
    end
    set_new = claim_ok && !busy_q[claim_reg];
    clr_old = wr_ok && busy_q[Rw] && !(claim_ok && (claim_reg == Rw));
    pend_d  = pend_q + CW'(set_new) - CW'(clr_old);
  end

  // NOTE: architectural state must read 0 after reset, so the storage array is
  // reset like any other flop rather than left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // The write in flight during reset is discarded, so it must not be bypassed.
  assign wr_live = RegWr && !rst;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rd_port (
      .regs    (regs_q),
      .busy    (busy_q),
      .wr_en   (wr_live),
      .wr_idx  (Rw),
      .wr_data (busW),
      .rd_idx  (Ra[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .rd_data (busR[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_busy (rd_busy[p])
    );
  end

  assign stall    = |rd_busy;
  assign pend_cnt = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table on the default configuration (with a BYPASS=0 twin), plus
// reset, claim-all and a random model comparison on a 4-port, 16-register build.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration and its BYPASS=0 twin share the same stimulus.
  logic        wr, cl;
  logic [4:0]  rw, creg;
  logic [31:0] busw;
  logic [9:0]  ra;
  logic [63:0] a_busr, b_busr;
  logic [1:0]  a_busy, b_busy;
  logic        a_stall, b_stall;
  logic [5:0]  a_pend, b_pend;

  // 4-port, 16-register, no zero register.
  logic         c_wr, c_cl;
  logic [3:0]   c_rw, c_creg;
  logic [31:0]  c_busw;
  logic [15:0]  c_ra;
  logic [127:0] c_busr;
  logic [3:0]   c_busy;
  logic         c_stall;
  logic [4:0]   c_pend;

  regfile_sb dut_a (
    .clk(clk), .rst(rst), .RegWr(wr), .Rw(rw), .busW(busw), .Ra(ra), .busR(a_busr),
    .claim_en(cl), .claim_reg(creg), .rd_busy(a_busy), .stall(a_stall), .pend_cnt(a_pend)
  );

  regfile_sb #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .RegWr(wr), .Rw(rw), .busW(busw), .Ra(ra), .busR(b_busr),
    .claim_en(cl), .claim_reg(creg), .rd_busy(b_busy), .stall(b_stall), .pend_cnt(b_pend)
  );

  regfile_sb #(.NUM_REGS(16), .ADDR_WIDTH(4), .NUM_RD(4), .ZERO_REG(1'b0)) dut_c (
    .clk(clk), .rst(rst), .RegWr(c_wr), .Rw(c_rw), .busW(c_busw), .Ra(c_ra), .busR(c_busr),
    .claim_en(c_cl), .claim_reg(c_creg), .rd_busy(c_busy), .stall(c_stall), .pend_cnt(c_pend)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic [4:0]  ra0, ra1;
    logic        cl;
    logic [4:0]  creg;
    logic [31:0] e_r0, e_r1;
    logic [1:0]  e_busy;
    logic [5:0]  e_pend;
    logic [31:0] e_nb_r0;
    logic [1:0]  e_nb_busy;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] w_idx, input logic [31:0] w_data,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic c, input logic [4:0] c_idx,
                              input logic [31:0] er0, input logic [31:0] er1,
                              input logic [1:0] eb, input logic [5:0] ep,
                              input logic [31:0] nbr0, input logic [1:0] nbb);
    vec_t v;
    v.wr = w; v.rw = w_idx; v.busw = w_data; v.ra0 = r0; v.ra1 = r1;
    v.cl = c; v.creg = c_idx; v.e_r0 = er0; v.e_r1 = er1; v.e_busy = eb;
    v.e_pend = ep; v.e_nb_r0 = nbr0; v.e_nb_busy = nbb;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vecs [NV];

  // Reference model state for the 16-register build.
  logic [31:0] m_regs [16];
  logic [15:0] m_busy;

  initial begin
    // Expected outputs are the combinational values seen before the edge.
    //            wr rw  busw          ra0 ra1 cl creg e_r0          e_r1          busy  pend nb_r0         nb_busy
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0, 32'h0,        2'b00);
    vecs[1]  = mk(0, 0, 32'h0,        5, 0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0, 32'hDEADBEEF, 2'b00);
    vecs[2]  = mk(1, 0, 32'h1,        0, 5, 0, 0, 32'h0,        32'hDEADBEEF, 2'b00, 0, 32'h0,        2'b00);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        2'b00);
    vecs[4]  = mk(1, 7, 32'h1234,     7, 5, 0, 0, 32'h1234,     32'hDEADBEEF, 2'b00, 0, 32'h0,        2'b00);
    vecs[5]  = mk(0, 0, 32'h0,        7, 9, 1, 9, 32'h1234,     32'h0,        2'b00, 0, 32'h1234,     2'b00);
    vecs[6]  = mk(0, 0, 32'h0,        7, 9, 0, 0, 32'h1234,     32'h0,        2'b10, 1, 32'h1234,     2'b10);
    vecs[7]  = mk(1, 9, 32'hAAAA5555, 9, 9, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 2'b00, 1, 32'h0,        2'b11);
    vecs[8]  = mk(0, 0, 32'h0,        9, 9, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 2'b00, 0, 32'hAAAA5555, 2'b00);
    vecs[9]  = mk(1, 4, 32'h44,       4, 3, 1, 4, 32'h44,       32'h0,        2'b00, 0, 32'h0,        2'b00);
    vecs[10] = mk(0, 0, 32'h0,        4, 0, 0, 0, 32'h44,       32'h0,        2'b01, 1, 32'h44,       2'b01);
    vecs[11] = mk(1, 4, 32'h45,       4, 2, 1, 2, 32'h45,       32'h0,        2'b00, 1, 32'h44,       2'b01);
    vecs[12] = mk(0, 0, 32'h0,        4, 2, 0, 0, 32'h45,       32'h0,        2'b10, 1, 32'h45,       2'b10);
    vecs[13] = mk(0, 0, 32'h0,        2, 2, 1, 2, 32'h0,        32'h0,        2'b11, 1, 32'h0,        2'b11);
    vecs[14] = mk(0, 0, 32'h0,        2, 2, 0, 0, 32'h0,        32'h0,        2'b11, 1, 32'h0,        2'b11);
    vecs[15] = mk(0, 0, 32'h0,        0, 2, 1, 0, 32'h0,        32'h0,        2'b10, 1, 32'h0,        2'b10);
    vecs[16] = mk(1, 2, 32'h22,       0, 2, 0, 0, 32'h0,        32'h22,       2'b00, 1, 32'h0,        2'b10);
    vecs[17] = mk(0, 0, 32'h0,        2, 4, 0, 0, 32'h22,       32'h45,       2'b00, 0, 32'h22,       2'b00);
    vecs[18] = mk(1, 6, 32'h66,       6, 1, 0, 0, 32'h66,       32'h0,        2'b00, 0, 32'h0,        2'b00);
    vecs[19] = mk(0, 0, 32'h0,        6, 6, 0, 0, 32'h66,       32'h66,       2'b00, 0, 32'h66,       2'b00);

    rst = 1'b1;
    wr = 0; rw = '0; busw = '0; ra = '0; cl = 0; creg = '0;
    c_wr = 0; c_rw = '0; c_busw = '0; c_ra = '0; c_cl = 0; c_creg = '0;
    #2;
    check("reset_busr", a_busr, 64'h0);
    check("reset_stall", a_stall, 1'b0);
    check("reset_pend", a_pend, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rw = vecs[i].rw; busw = vecs[i].busw;
      ra = {vecs[i].ra1, vecs[i].ra0}; cl = vecs[i].cl; creg = vecs[i].creg;
      #1;
      check($sformatf("v%0d_busr0", i), a_busr[31:0], vecs[i].e_r0);
      check($sformatf("v%0d_busr1", i), a_busr[63:32], vecs[i].e_r1);
      check($sformatf("v%0d_rd_busy", i), a_busy, vecs[i].e_busy);
      check($sformatf("v%0d_stall", i), a_stall, |vecs[i].e_busy);
      check($sformatf("v%0d_pend", i), a_pend, vecs[i].e_pend);
      check($sformatf("v%0d_nb_busr0", i), b_busr[31:0], vecs[i].e_nb_r0);
      check($sformatf("v%0d_nb_rd_busy", i), b_busy, vecs[i].e_nb_busy);
      check($sformatf("v%0d_nb_stall", i), b_stall, |vecs[i].e_nb_busy);
      check($sformatf("v%0d_nb_pend", i), b_pend, vecs[i].e_pend);
    end

    // Reset asserted mid-cycle while a write to r3 and a claim of r8 are pending.
    @(negedge clk);
    wr = 1; rw = 5'd3; busw = 32'h33; cl = 1; creg = 5'd8; ra = {5'd3, 5'd5};
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busr", a_busr, 64'h0);
    check("rst_mid_stall", a_stall, 1'b0);
    check("rst_mid_pend", a_pend, 6'd0);
    @(negedge clk);
    rst = 1'b0; wr = 0; cl = 0; ra = {5'd8, 5'd3};
    #1;
    check("rst_after_r3", a_busr[31:0], 32'h0);
    check("rst_after_busy", a_busy, 2'b00);
    check("rst_after_pend", a_pend, 6'd0);
    ra = {5'd7, 5'd5};
    #1;
    check("rst_after_r5_r7", a_busr, 64'h0);

    // Without a zero register, r0 is an ordinary writable register.
    @(negedge clk);
    c_wr = 1; c_rw = 4'd0; c_busw = 32'hABCD; c_ra = '0;
    #1 check("c_r0_bypass", c_busr[31:0], 32'hABCD);
    @(negedge clk);
    c_wr = 0;
    #1 check("c_r0_stored", c_busr[127:96], 32'hABCD);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c_cl = 1; c_creg = 4'(i);
    end
    @(negedge clk);
    c_cl = 0; c_ra = {4'd15, 4'd10, 4'd5, 4'd0};
    #1;
    check("c_claim_all_pend", c_pend, 5'd16);
    check("c_claim_all_busy", c_busy, 4'hF);
    check("c_claim_all_stall", c_stall, 1'b1);
    @(negedge clk);
    c_cl = 1; c_creg = 4'd7;
    @(negedge clk);
    c_cl = 0;
    #1 check("c_reclaim_no_wrap", c_pend, 5'd16);

    @(negedge clk);
    rst = 1'b1;
    #1 check("c_reset_pend", c_pend, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [127:0] e_busr;
      logic [3:0]   e_busy;
      logic [4:0]   e_pend;
      logic         hit;
      logic [3:0]   idx;
      @(negedge clk);
      c_wr = 1'($urandom_range(0, 1)); c_rw = 4'($urandom_range(0, 15));
      c_busw = $urandom; c_ra = 16'($urandom);
      c_cl = 1'($urandom_range(0, 1)); c_creg = 4'($urandom_range(0, 15));
      #1;
      e_pend = '0;
      for (int r = 0; r < 16; r++) e_pend += 5'(m_busy[r]);
      for (int p = 0; p < 4; p++) begin
        idx = c_ra[p*4 +: 4];
        hit = c_wr && (c_rw == idx);
        e_busr[p*32 +: 32] = hit ? c_busw : m_regs[idx];
        e_busy[p] = m_busy[idx] && !hit;
      end
      check($sformatf("rand%0d_busr", cyc), c_busr, e_busr);
      check($sformatf("rand%0d_rd_busy", cyc), c_busy, e_busy);
      check($sformatf("rand%0d_stall", cyc), c_stall, |e_busy);
      check($sformatf("rand%0d_pend", cyc), c_pend, e_pend);
      if (c_wr) begin
        m_regs[c_rw] = c_busw;
        m_busy[c_rw] = 1'b0;
      end
      if (c_cl) m_busy[c_creg] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
